// File: rtl/instr_sequencer.sv
// Fetch/issue controller: walks a program counter through a small local
// instruction memory and hands one opcode at a time to decode over valid/ready.
module instr_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned AW      = 2,
  parameter logic [31:0] HALT_OP = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  output logic [31:0]   opcode,
  output logic          opcode_valid,
  input  logic          exec_ready,
  output logic [AW:0]   pc,
  output logic [AW:0]   issued,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_W  = {(AW+1){1'b0}};
  localparam logic [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};

  logic [1:0]  state_q, state_d;
  logic [31:0] opcode_q, opcode_d;
  logic        valid_q, valid_d;
  logic [AW:0] pc_q, pc_d;
  logic [AW:0] issued_q, issued_d;
  logic [AW:0] len_q, len_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] mem_q [DEPTH];

  logic        mem_we_s;
  logic [31:0] rd_word_s;
  logic        fire_s;
  logic [AW:0] pc_inc_s;

  // Memory is only writable while idle, so a running program never changes
  assign mem_we_s  = (state_q == S_IDLE) && load_en;
  assign rd_word_s = mem_q[pc_q[AW-1:0]];
  assign fire_s    = (state_q == S_ISSUE) && valid_q && exec_ready;
  assign pc_inc_s  = pc_q + ONE_W;

  // Program memory write port; deliberately not reset so contents survive rst
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Next-state logic for the fetch/issue sequence
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    issued_d = issued_q;
    len_d    = len_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
          pc_d     = ZERO_W;
          issued_d = ZERO_W;
          if (len_d == ZERO_W) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        // A load in the start cycle has already committed, so this read sees it
        opcode_d = rd_word_s;
        if (rd_word_s == HALT_OP) begin
          valid_d = 1'b0;
          state_d = S_DONE;
        end else begin
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fire_s) begin
          valid_d  = 1'b0;
          pc_d     = pc_inc_s;
          issued_d = issued_q + ONE_W;
          if (pc_inc_s == len_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opcode_q <= 32'h0000_0000;
      valid_q  <= 1'b0;
      pc_q     <= ZERO_W;
      issued_q <= ZERO_W;
      len_q    <= ZERO_W;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      issued_q <= issued_d;
      len_q    <= len_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign opcode       = opcode_q;
  assign opcode_valid = valid_q;
  assign pc           = pc_q;
  assign issued       = issued_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized
// programs and back-pressure, checked against a timeline model of the run.
module tb_instr_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          start;
  logic [AW:0]   prog_len;
  logic [31:0]   opcode;
  logic          opcode_valid;
  logic          exec_ready;
  logic [AW:0]   pc;
  logic [AW:0]   issued;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .HALT_OP(HALT)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .prog_len(prog_len),
    .opcode(opcode), .opcode_valid(opcode_valid), .exec_ready(exec_ready),
    .pc(pc), .issued(issued), .busy(busy), .done(done)
  );

  int checks = 0;
  int passes = 0;

  logic [31:0] mem_m [DEPTH];
  bit          ready_pat [0:299];
  int          inj_cycle = -1;

  logic [31:0] obs_ops[$];
  int          obs_cyc[$];
  int          obs_done_cyc, obs_done_cnt, obs_first_valid;
  bit          obs_halt_valid, obs_unstable;
  logic [AW:0] obs_pc, obs_issued;
  logic        obs_busy1, obs_busy_after, obs_done_after;

  logic [31:0] exp_ops[$];
  int          exp_cyc[$];
  int          exp_done_cyc;

  task automatic set_ready(input int pct);
    for (int j = 0; j < 300; j++)
      ready_pat[j] = (j >= 100) || ($urandom_range(99, 0) < pct);
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    mem_m[a] = d;
  endtask

  // Cycle j counts rising edges since start was sampled; an instruction costs
  // one fetch cycle plus one issue cycle per ready=0 cycle plus the fire cycle.
  task automatic model_run(input logic [AW:0] plen);
    int len, j;
    exp_ops.delete(); exp_cyc.delete();
    if (int'(plen) > DEPTH) len = DEPTH; else len = int'(plen);
    j = 1;
    exp_done_cyc = 1;
    for (int i = 0; i < len; i++) begin
      if (mem_m[i] == HALT) begin
        exp_done_cyc = j + 1;
        return;
      end
      j++;
      while (!ready_pat[j] && j < 299) j++;
      exp_ops.push_back(mem_m[i]);
      exp_cyc.push_back(j);
      j++;
      exp_done_cyc = j;
    end
  endtask

  task automatic run_prog(input logic [AW:0] plen);
    bit prev_stall;
    logic [31:0] prev_op;
    obs_ops.delete(); obs_cyc.delete();
    obs_done_cyc = -1; obs_done_cnt = 0; obs_first_valid = -1;
    obs_halt_valid = 1'b0; obs_unstable = 1'b0;
    obs_busy1 = 1'b0; obs_busy_after = 1'b1; obs_done_after = 1'b1;
    obs_pc = '1; obs_issued = '1;
    prev_stall = 1'b0; prev_op = 32'h0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      start = (j == 0);
      prog_len = plen;
      exec_ready = ready_pat[j];
      if (j == inj_cycle) begin
        load_en = 1'b1; load_addr = 2'd1; load_data = 32'h99; start = 1'b1;
      end else begin
        load_en = 1'b0;
      end
      if (j >= 1) begin
        if (j == 1) obs_busy1 = busy;
        if (opcode_valid && obs_first_valid < 0) obs_first_valid = j;
        if (opcode_valid && opcode == HALT) obs_halt_valid = 1'b1;
        if (prev_stall && (!opcode_valid || opcode !== prev_op)) obs_unstable = 1'b1;
        if (opcode_valid && exec_ready) begin
          obs_ops.push_back(opcode);
          obs_cyc.push_back(j);
        end
        if (done) begin
          obs_done_cnt++;
          if (obs_done_cyc < 0) begin
            obs_done_cyc = j; obs_pc = pc; obs_issued = issued;
          end
        end
        prev_stall = opcode_valid && !exec_ready;
        prev_op = opcode;
        if (obs_done_cyc >= 0 && j == obs_done_cyc + 1) begin
          obs_busy_after = busy; obs_done_after = done;
        end
        if (obs_done_cyc >= 0 && j == obs_done_cyc + 2) break;
      end
    end
    start = 1'b0; load_en = 1'b0; exec_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({opcode, opcode_valid, pc, issued, busy, done} !== '0) begin
      $display("FAIL reset_outputs: got op=%h v=%b pc=%0d iss=%0d busy=%b done=%b, want all 0",
               opcode, opcode_valid, pc, issued, busy, done);
    end else passes++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    load_word(2'd0, 32'h11); load_word(2'd1, 32'h22);
    load_word(2'd2, 32'h33); load_word(2'd3, 32'h44);
    set_ready(100);
    model_run(3'd4);
    run_prog(3'd4);
    checks++;
    if (obs_ops.size() != 4) $display("FAIL basic_count: got %0d fires, want 4", obs_ops.size());
    else passes++;
    for (int i = 0; i < 4 && i < obs_ops.size(); i++) begin
      checks++;
      if (obs_ops[i] !== exp_ops[i] || obs_cyc[i] != exp_cyc[i])
        $display("FAIL basic_fire%0d: got %h@%0d, want %h@%0d", i, obs_ops[i], obs_cyc[i], exp_ops[i], exp_cyc[i]);
      else passes++;
    end
    checks++;
    if (obs_done_cyc != exp_done_cyc) $display("FAIL basic_done: got cycle %0d, want %0d", obs_done_cyc, exp_done_cyc);
    else passes++;
    checks++;
    if (obs_pc !== 3'd4 || obs_issued !== 3'd4) $display("FAIL basic_pc_issued: got pc=%0d iss=%0d, want 4/4", obs_pc, obs_issued);
    else passes++;
    checks++;
    if (obs_busy1 !== 1'b1 || obs_first_valid != 2) $display("FAIL basic_latency: got busy1=%b first_valid=%0d, want 1/2", obs_busy1, obs_first_valid);
    else passes++;
    checks++;
    if (obs_busy_after !== 1'b0 || obs_done_after !== 1'b0) $display("FAIL basic_end: got busy=%b done=%b after done, want 0/0", obs_busy_after, obs_done_after);
    else passes++;
  endtask

  task automatic test_backpressure();
    set_ready(100);
    ready_pat[4] = 1'b0; ready_pat[5] = 1'b0; ready_pat[6] = 1'b0;
    model_run(3'd4);
    run_prog(3'd4);
    checks++;
    if (obs_ops.size() != 4 || obs_ops[1] !== 32'h22 || obs_cyc[1] != 7)
      $display("FAIL bp_fire: got n=%0d, want 0x22 fired once at cycle 7", obs_ops.size());
    else passes++;
    checks++;
    if (obs_done_cyc != 12 || obs_done_cyc != exp_done_cyc) $display("FAIL bp_done: got cycle %0d, want 12", obs_done_cyc);
    else passes++;
    checks++;
    if (obs_unstable !== 1'b0) $display("FAIL bp_stable: got opcode change during stall, want stable");
    else passes++;
  endtask

  task automatic test_halt();
    load_word(2'd2, HALT);
    set_ready(100);
    model_run(3'd4);
    run_prog(3'd4);
    checks++;
    if (obs_ops.size() != 2 || obs_ops[0] !== 32'h11 || obs_ops[1] !== 32'h22)
      $display("FAIL halt_fires: got %0d fires, want 0x11,0x22", obs_ops.size());
    else passes++;
    checks++;
    if (obs_done_cyc != exp_done_cyc || obs_issued !== 3'd2) $display("FAIL halt_done: got cycle %0d iss=%0d, want %0d/2", obs_done_cyc, obs_issued, exp_done_cyc);
    else passes++;
    checks++;
    if (obs_halt_valid !== 1'b0) $display("FAIL halt_valid: got HALT with valid high, want never");
    else passes++;
    load_word(2'd2, 32'h33);
  endtask

  task automatic test_len_bounds();
    set_ready(100);
    run_prog(3'd0);
    checks++;
    if (obs_done_cyc != 1 || obs_first_valid != -1 || obs_ops.size() != 0)
      $display("FAIL zero_len: got done@%0d first_valid=%0d, want done@1 and no valid", obs_done_cyc, obs_first_valid);
    else passes++;
    model_run(3'd7);
    run_prog(3'd7);
    checks++;
    if (obs_ops.size() != 4 || obs_issued !== 3'd4 || obs_done_cyc != exp_done_cyc)
      $display("FAIL clamp: got %0d fires iss=%0d, want 4/4", obs_ops.size(), obs_issued);
    else passes++;
  endtask

  task automatic test_ignore_busy();
    set_ready(100);
    inj_cycle = 1;
    model_run(3'd4);
    run_prog(3'd4);
    inj_cycle = -1;
    checks++;
    if (obs_ops.size() != 4 || obs_ops[1] !== 32'h22 || obs_done_cyc != exp_done_cyc)
      $display("FAIL busy_ignore: got n=%0d done@%0d, want original run done@%0d", obs_ops.size(), obs_done_cyc, exp_done_cyc);
    else passes++;
    run_prog(3'd4);
    checks++;
    if (obs_ops.size() != 4 || obs_ops[1] !== 32'h22) $display("FAIL busy_nowrite: got mem[1] issued as %h, want 22", obs_ops.size() > 1 ? obs_ops[1] : 32'h0);
    else passes++;
  endtask

  task automatic test_load_start();
    set_ready(100);
    inj_cycle = 0;
    mem_m[1] = 32'h99;
    model_run(3'd4);
    run_prog(3'd4);
    inj_cycle = -1;
    checks++;
    if (obs_ops.size() != 4 || obs_ops[1] !== exp_ops[1]) $display("FAIL load_start: got mem[1] issued as %h, want %h",
                                   obs_ops.size() > 1 ? obs_ops[1] : 32'h0, exp_ops[1]);
    else passes++;
    load_word(2'd1, 32'h22);
  endtask

  task automatic test_reset_mid_run();
    bit found;
    int dcnt;
    @(negedge clk);
    start = 1'b1; prog_len = 3'd4; exec_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (opcode_valid && opcode == 32'h33) found = 1'b1;
    end
    rst = 1'b1; exec_ready = 1'b0;
    checks++;
    if (!found) $display("FAIL rst_mid_reach: got 0x33 never valid, want it valid");
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({opcode, opcode_valid, pc, issued, busy, done} !== '0)
      $display("FAIL rst_mid_outputs: got op=%h v=%b pc=%0d iss=%0d busy=%b, want all 0", opcode, opcode_valid, pc, issued, busy);
    else passes++;
    dcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    checks++;
    if (dcnt != 0) $display("FAIL rst_mid_idle: got %0d busy/done cycles, want 0", dcnt);
    else passes++;
    set_ready(100);
    model_run(3'd4);
    run_prog(3'd4);
    checks++;
    if (obs_ops.size() != 4 || obs_ops[0] !== 32'h11 || obs_ops[3] !== 32'h44)
      $display("FAIL rst_mid_replay: got %0d fires, want original 11..44", obs_ops.size());
    else passes++;
  endtask

  task automatic test_random();
    logic [AW:0] plen;
    for (int it = 0; it < 20; it++) begin
      for (int a = 0; a < DEPTH; a++)
        load_word(a[AW-1:0], ($urandom_range(7, 0) == 0) ? HALT : {$urandom} & 32'hFFFF_FFFE);
      plen = 3'($urandom_range(7, 0));
      set_ready($urandom_range(100, 30));
      model_run(plen);
      run_prog(plen);
      checks++;
      if (obs_ops.size() != exp_ops.size()) $display("FAIL rnd%0d_count: got %0d, want %0d", it, obs_ops.size(), exp_ops.size());
      else passes++;
      for (int i = 0; i < exp_ops.size() && i < obs_ops.size(); i++) begin
        checks++;
        if (obs_ops[i] !== exp_ops[i] || obs_cyc[i] != exp_cyc[i])
          $display("FAIL rnd%0d_fire%0d: got %h@%0d, want %h@%0d", it, i, obs_ops[i], obs_cyc[i], exp_ops[i], exp_cyc[i]);
        else passes++;
      end
      checks++;
      if (obs_done_cyc != exp_done_cyc || obs_issued !== 3'(exp_ops.size()) || obs_pc !== 3'(exp_ops.size()))
        $display("FAIL rnd%0d_end: got done@%0d pc=%0d iss=%0d, want done@%0d pc=iss=%0d",
                 it, obs_done_cyc, obs_pc, obs_issued, exp_done_cyc, exp_ops.size());
      else passes++;
      checks++;
      if (obs_unstable || obs_halt_valid || obs_done_after !== 1'b0 || obs_done_cnt != 1)
        $display("FAIL rnd%0d_rules: got unstable=%b halt_valid=%b done_pulses=%0d, want 0/0/1",
                 it, obs_unstable, obs_halt_valid, obs_done_cnt);
      else passes++;
    end
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; prog_len = '0; exec_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_halt();
    test_len_bounds();
    test_ignore_busy();
    test_load_start();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
